dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory BRAM port A between three requesters: core execution, the C2 loader (writes) and the C2 dumper (reads).
- Replaces the combinational loader/core glue with a registered arbitration scheme. Core keeps absolute, zero-wait priority.
- Loader and dumper are served round-robin in cycles where the core is not accessing the port.
- Starving side requests raise a stall request toward the core. Read data is routed by a latency-matched tag pipeline.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte enables are DATA_W/8
RD_LATENCY, 1, BRAM read latency in cycles (1..3)
STARVE_LIMIT, 16, wait cycles before stall_req_o asserts (>=2)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
core_active_i  in  1  core not stalled; core owns the port this cycle
core_addr_i  in  ADDR_W  core address
core_wdata_i  in  DATA_W  core write data
core_be_i  in  DATA_W/8  core byte write mask (0 = read)
core_rdata_o  out  DATA_W  core read data
ldr_req_i  in  1  loader write request (held until granted)
ldr_gnt_o  out  1  loader write performed this cycle
ldr_addr_i  in  ADDR_W  loader address
ldr_wdata_i  in  DATA_W  loader word
dmp_req_i  in  1  dumper read request (held until granted)
dmp_gnt_o  out  1  dumper read issued this cycle
dmp_addr_i  in  ADDR_W  dumper address
dmp_rdata_o  out  DATA_W  dumper read data
dmp_rvalid_o  out  1  dmp_rdata_o valid
mem_en_o  out  1  BRAM enable
mem_we_o  out  DATA_W/8  BRAM byte write enables
mem_addr_o  out  ADDR_W  BRAM address
mem_wdata_o  out  DATA_W  BRAM write data
mem_rdata_i  in  DATA_W  BRAM read data
stall_req_o  out  1  request core stall (ORed into core stall at top)
busy_o  out  1  side read in flight or side request pending

Behaviour:
Reset values:
- stall_req_o=0, dmp_rvalid_o=0, busy_o=0.
- RR pointer = loader; starve counter = 0; tag pipeline empty.
- All grants are combinational and therefore 0 whenever reqs are 0.

Port ownership (combinational):
- core_active_i=1: core owns the port. mem_en_o=1, mem_we_o=core_be_i, addr/wdata from core. ldr_gnt_o=dmp_gnt_o=0.
- core_active_i=0 with at least one side request: grant exactly one side requester.
  - Single requester: grant it.
  - Both requesting: grant the RR pointer's side. Pointer flips to the other side on every side grant (registered).
- Loader grant: mem_we_o=all ones, addr/wdata from loader.
- Dumper grant: mem_we_o=0, addr from dumper.
- No owner: mem_en_o=0, mem_we_o=0, addr/wdata=0.
- A side request that loses to core_active_i in the same cycle is not granted. The requester holds req; there is no partial transfer.

Read routing:
- Tag shift register of depth RD_LATENCY records {dumper_read} per cycle.
- dmp_rvalid_o = tag at the output stage. dmp_rdata_o = mem_rdata_i qualified by it; 0 when not valid.
- core_rdata_o = mem_rdata_i unconditionally. The core's fixed timing is unchanged.
- Loader writes produce no response.

Starvation:
- Counter increments each cycle with (ldr_req_i|dmp_req_i) & core_active_i, saturating at STARVE_LIMIT.
- It clears on any side grant.
- stall_req_o is registered: it sets when the counter reaches STARVE_LIMIT and clears in the cycle after the first side grant. This guarantees one transfer per forced stall.
- With no side request, the counter clears and stall_req_o drops next cycle.

busy_o = ldr_req_i | dmp_req_i | any tag set in the pipeline.

Reset mid-operation:
- In-flight tags are discarded, so no dmp_rvalid_o after reset.
- Grants drop immediately because they are combinational on registered state.

Decomposition:
- Shared package dmem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_CORE, OWN_LDR, OWN_DMP}
  - RD_LATENCY_MAX constant
  - byte-enable width function
- One natural sub-module: arb_tag_pipe, a parameterised RD_LATENCY-deep valid/tag shift register with async clear.

Test Plan:
- Core priority: core_active_i=1, core_be_i=4'b0011, ldr_req_i=1 for 5 cycles.
  - Expect mem_we_o=0011 each cycle and ldr_gnt_o=0 throughout.
  - Expect stall_req_o=0 (counter=5 < 16).
- Round robin: core_active_i=0, both reqs held high 4 cycles.
  - Expect grants ldr,dmp,ldr,dmp.
  - Expect dmp_rvalid_o exactly RD_LATENCY cycles after each dmp_gnt_o.
  - Data matches preloaded BRAM words (addr 0x10 -> 0xDEADBEEF).
- Starvation: core_active_i=1, dmp_req_i=1 continuously.
  - Expect stall_req_o=1 in cycle 17.
  - Drop core_active_i at cycle 18: expect dmp_gnt_o=1 in cycle 18 and stall_req_o=0 in cycle 19.
- Loader write then dump readback:
  - Loader writes 0xCAFEF00D to addr 0x40 with mem_we_o=4'hF.
  - Dumper reads 0x40: dmp_rdata_o=0xCAFEF00D with dmp_rvalid_o pulse of 1 cycle.
- Core resume during in-flight dump read (RD_LATENCY=2):
  - Dumper granted at t, core_active_i=1 at t+1 with a core read.
  - Expect dmp_rvalid_o only at t+2 with dumper data; core receives its own data at t+3.
- Reset mid-read: assert rst_ni low one cycle after dmp_gnt_o.
  - Expect dmp_rvalid_o, stall_req_o and busy_o all 0 after reset and no late response.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   owner_e        : which requester drives BRAM port A in the current cycle
//   RD_LATENCY_MAX : largest supported BRAM read latency
//   be_width()     : byte-enable width for a given data width
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_LDR  = 2'd2,
        OWN_DMP  = 2'd3
    } owner_e;

    localparam int RD_LATENCY_MAX = 3;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Latency-matched tag shift register. A tag entered in the cycle a read is
// issued emerges at tag_o exactly DEPTH cycles later, aligned with the BRAM
// read data. Asynchronous clear drops every in-flight tag.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear
//   tag_i  : tag for the access issued this cycle
//   tag_o  : tag belonging to the data on the BRAM output this cycle
//   any_o  : at least one tag is in flight
module arb_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tag_i,
    output logic tag_o,
    output logic any_o
);

    logic [DEPTH-1:0] tags_r;

    // Shift tags one stage per cycle; stage 0 captures the current issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tags_r <= '0;
        end else begin
            tags_r[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                tags_r[i] <= tags_r[i-1];
            end
        end
    end

    assign tag_o = tags_r[DEPTH-1];
    assign any_o = |tags_r;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter for data-memory BRAM port A. The core has absolute, zero-wait
// priority; the C2 loader (writes) and C2 dumper (reads) share the idle
// cycles round-robin. Side requests kept waiting by the core raise a
// registered stall request. Dumper read data is qualified by a tag pipeline
// matched to the BRAM read latency.
//   core_*  : core access (core_be_i == 0 means read), read data returned raw
//   ldr_*   : loader write request/grant, address and word
//   dmp_*   : dumper read request/grant, address, read data and valid
//   mem_*   : BRAM port A
//   stall_req_o : ask the core to stall so a starving side request can run
//   busy_o      : side request pending or dumper read in flight
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          core_active_i,
    input  logic [ADDR_W-1:0]             core_addr_i,
    input  logic [DATA_W-1:0]             core_wdata_i,
    input  logic [be_width(DATA_W)-1:0]   core_be_i,
    output logic [DATA_W-1:0]             core_rdata_o,
    input  logic                          ldr_req_i,
    output logic                          ldr_gnt_o,
    input  logic [ADDR_W-1:0]             ldr_addr_i,
    input  logic [DATA_W-1:0]             ldr_wdata_i,
    input  logic                          dmp_req_i,
    output logic                          dmp_gnt_o,
    input  logic [ADDR_W-1:0]             dmp_addr_i,
    output logic [DATA_W-1:0]             dmp_rdata_o,
    output logic                          dmp_rvalid_o,
    output logic                          mem_en_o,
    output logic [be_width(DATA_W)-1:0]   mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic                          stall_req_o,
    output logic                          busy_o
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    owner_e           owner_s;
    logic             rr_r;           // 1'b0: loader wins a tie, 1'b1: dumper wins
    logic             side_req_s;
    logic             side_gnt_s;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_s;
    logic             stall_r;
    logic             stall_s;
    logic             tag_out_s;
    logic             tag_any_s;

    assign side_req_s = ldr_req_i | dmp_req_i;

    // Decide the port owner for this cycle from the requests and RR pointer.
    always_comb begin
        owner_s = OWN_NONE;
        if (core_active_i) begin
            owner_s = OWN_CORE;
        end else if (ldr_req_i && dmp_req_i) begin
            owner_s = rr_r ? OWN_DMP : OWN_LDR;
        end else if (ldr_req_i) begin
            owner_s = OWN_LDR;
        end else if (dmp_req_i) begin
            owner_s = OWN_DMP;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Steer the BRAM port and the grants from the owner.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = {BE_W{1'b0}};
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_wdata_o = {DATA_W{1'b0}};
        ldr_gnt_o   = 1'b0;
        dmp_gnt_o   = 1'b0;
        case (owner_s)
            OWN_CORE: begin
                mem_en_o    = 1'b1;
                mem_we_o    = core_be_i;
                mem_addr_o  = core_addr_i;
                mem_wdata_o = core_wdata_i;
            end
            OWN_LDR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = {BE_W{1'b1}};
                mem_addr_o  = ldr_addr_i;
                mem_wdata_o = ldr_wdata_i;
                ldr_gnt_o   = 1'b1;
            end
            OWN_DMP: begin
                mem_en_o    = 1'b1;
                mem_addr_o  = dmp_addr_i;
                dmp_gnt_o   = 1'b1;
            end
            default: begin
                mem_en_o    = 1'b0;
            end
        endcase
    end

    assign side_gnt_s = ldr_gnt_o | dmp_gnt_o;

    // Starvation counter and stall request next state. The stall is set from
    // the counter's next value so it rises in the same cycle the counter hits
    // the limit, and it stays up until a side grant has actually happened.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        stall_s      = stall_r;
        if (side_gnt_s || !side_req_s) begin
            starve_cnt_s = {CNT_W{1'b0}};
        end else if (core_active_i && (starve_cnt_r != LIMIT)) begin
            starve_cnt_s = starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_s = starve_cnt_r;
        end

        if (side_gnt_s || !side_req_s) begin
            stall_s = 1'b0;
        end else if (starve_cnt_s == LIMIT) begin
            stall_s = 1'b1;
        end else begin
            stall_s = stall_r;
        end
    end

    // Round-robin pointer and starvation state registers. After a side grant
    // the pointer favours the side that was not served.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_r         <= 1'b0;
            starve_cnt_r <= {CNT_W{1'b0}};
            stall_r      <= 1'b0;
        end else begin
            if (ldr_gnt_o) begin
                rr_r <= 1'b1;
            end else if (dmp_gnt_o) begin
                rr_r <= 1'b0;
            end else begin
                rr_r <= rr_r;
            end
            starve_cnt_r <= starve_cnt_s;
            stall_r      <= stall_s;
        end
    end

    arb_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (dmp_gnt_o),
        .tag_o  (tag_out_s),
        .any_o  (tag_any_s)
    );

    assign dmp_rvalid_o = tag_out_s;
    assign dmp_rdata_o  = tag_out_s ? mem_rdata_i : {DATA_W{1'b0}};
    assign core_rdata_o = mem_rdata_i;
    assign stall_req_o  = stall_r;
    assign busy_o       = side_req_s | tag_any_s;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int LIM = 16;

    logic          clk;
    logic          rst_n;
    logic          core_active;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [3:0]    core_be;
    logic [DW-1:0] core_rdata;
    logic          ldr_req;
    logic          ldr_gnt;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          dmp_req;
    logic          dmp_gnt;
    logic [AW-1:0] dmp_addr;
    logic [DW-1:0] dmp_rdata;
    logic          dmp_rvalid;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_req;
    logic          busy;

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .STARVE_LIMIT(LIM)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_active_i(core_active), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_be_i(core_be), .core_rdata_o(core_rdata),
        .ldr_req_i(ldr_req), .ldr_gnt_o(ldr_gnt), .ldr_addr_i(ldr_addr),
        .ldr_wdata_i(ldr_wdata),
        .dmp_req_i(dmp_req), .dmp_gnt_o(dmp_gnt), .dmp_addr_i(dmp_addr),
        .dmp_rdata_o(dmp_rdata), .dmp_rvalid_o(dmp_rvalid),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .stall_req_o(stall_req), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: read-first, byte writes, LAT-cycle read pipeline, word index addr[9:2].
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] rd_pipe [0:LAT-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            ram[4] <= 32'hDEADBEEF;   // 0x10
            ram[5] <= 32'h12345678;   // 0x14
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= 32'h0;
        end else begin
            if (mem_en) begin
                rd_pipe[0] <= ram[mem_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        core_active = 1'b0; core_be = 4'h0;
        ldr_req = 1'b0; dmp_req = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) next_cyc();
    endtask

    typedef struct {
        logic        ca;
        logic [3:0]  be;
        logic        lr;
        logic        dr;
        logic        en;
        logic [3:0]  we;
        logic        lg;
        logic        dg;
        logic [31:0] addr;
        logic        busy;
    } vec_t;

    vec_t vt [6];

    initial begin
        //           ca    be     lr    dr    en    we     lg    dg    addr          busy
        vt[0] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[1] = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 32'h100,      1'b1};
        vt[2] = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 32'h100,      1'b1};
        vt[3] = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 32'h100,      1'b0};
        vt[4] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 32'h200,      1'b1};
        vt[5] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 32'h300,      1'b1};

        rst_n = 1'b0;
        drive_idle();
        core_addr = 32'h100; core_wdata = 32'h5A5A5A5A;
        ldr_addr = 32'h200; ldr_wdata = 32'hA5A5A5A5;
        dmp_addr = 32'h300;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_rvalid", dmp_rvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", {ldr_gnt, dmp_gnt}, 2'b00);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // Ownership table
        for (int i = 0; i < 6; i++) begin
            core_active = vt[i].ca; core_be = vt[i].be;
            ldr_req = vt[i].lr; dmp_req = vt[i].dr;
            @(negedge clk);
            chk($sformatf("vec%0d_en", i), mem_en, vt[i].en);
            chk($sformatf("vec%0d_we", i), mem_we, vt[i].we);
            chk($sformatf("vec%0d_lgnt", i), ldr_gnt, vt[i].lg);
            chk($sformatf("vec%0d_dgnt", i), dmp_gnt, vt[i].dg);
            chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].addr);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("vec%0d_rvalid", i), dmp_rvalid, 1'b0);
            next_cyc();
        end
        idle(4);

        // Core priority over a held loader request
        for (int c = 1; c <= 5; c++) begin
            core_active = 1'b1; core_be = 4'b0011; ldr_req = 1'b1;
            @(negedge clk);
            chk($sformatf("prio%0d_we", c), mem_we, 4'b0011);
            chk($sformatf("prio%0d_lgnt", c), ldr_gnt, 1'b0);
            chk($sformatf("prio%0d_stall", c), stall_req, 1'b0);
            next_cyc();
        end
        idle(3);

        // Round robin with both side requests held
        ldr_addr = 32'h80; ldr_wdata = 32'h11111111;
        for (int k = 0; k < 7; k++) begin
            ldr_req = (k < 4); dmp_req = (k < 4);
            dmp_addr = (k < 2) ? 32'h10 : 32'h14;
            @(negedge clk);
            if (k < 4) begin
                chk($sformatf("rr%0d_lgnt", k), ldr_gnt, (k % 2) == 0);
                chk($sformatf("rr%0d_dgnt", k), dmp_gnt, (k % 2) == 1);
            end
            chk($sformatf("rr%0d_rvalid", k), dmp_rvalid, (k == 3) || (k == 5));
            chk($sformatf("rr%0d_rdata", k), dmp_rdata,
                (k == 3) ? 32'hDEADBEEF : ((k == 5) ? 32'h12345678 : 32'h0));
            chk($sformatf("rr%0d_busy", k), busy, k < 6);
            next_cyc();
        end
        idle(3);

        // Starvation of a dumper request by a continuously active core
        dmp_addr = 32'h10;
        for (int c = 1; c <= 19; c++) begin
            core_active = (c <= 17); dmp_req = (c <= 18);
            @(negedge clk);
            if (c <= 17) begin
                chk($sformatf("starve%0d_stall", c), stall_req, c == 17);
                chk($sformatf("starve%0d_dgnt", c), dmp_gnt, 1'b0);
            end else if (c == 18) begin
                chk("starve18_dgnt", dmp_gnt, 1'b1);
                chk("starve18_stall", stall_req, 1'b1);
            end else begin
                chk("starve19_stall", stall_req, 1'b0);
            end
            next_cyc();
        end
        idle(4);

        // Loader write then dumper readback
        ldr_req = 1'b1; ldr_addr = 32'h40; ldr_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("lw_gnt", ldr_gnt, 1'b1);
        chk("lw_we", mem_we, 4'hF);
        chk("lw_addr", mem_addr, 32'h40);
        chk("lw_wdata", mem_wdata, 32'hCAFEF00D);
        next_cyc();
        ldr_req = 1'b0; dmp_req = 1'b1; dmp_addr = 32'h40;
        @(negedge clk);
        chk("rb_gnt", dmp_gnt, 1'b1);
        chk("rb_we", mem_we, 4'h0);
        next_cyc();
        dmp_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("rb%0d_rvalid", k), dmp_rvalid, k == 2);
            chk($sformatf("rb%0d_rdata", k), dmp_rdata, (k == 2) ? 32'hCAFEF00D : 32'h0);
            next_cyc();
        end
        idle(2);

        // Core resumes while a dumper read is in flight
        dmp_req = 1'b1; dmp_addr = 32'h14;
        @(negedge clk);
        chk("cr_t_dgnt", dmp_gnt, 1'b1);
        next_cyc();
        dmp_req = 1'b0; core_active = 1'b1; core_be = 4'h0; core_addr = 32'h10;
        @(negedge clk);
        chk("cr_t1_rvalid", dmp_rvalid, 1'b0);
        next_cyc();
        core_active = 1'b0;
        @(negedge clk);
        chk("cr_t2_rvalid", dmp_rvalid, 1'b1);
        chk("cr_t2_rdata", dmp_rdata, 32'h12345678);
        next_cyc();
        @(negedge clk);
        chk("cr_t3_rvalid", dmp_rvalid, 1'b0);
        chk("cr_t3_rdata", dmp_rdata, 32'h0);
        chk("cr_t3_core", core_rdata, 32'hDEADBEEF);
        next_cyc();
        idle(2);

        // Reset one cycle after a dumper grant
        dmp_req = 1'b1; dmp_addr = 32'h10;
        @(negedge clk);
        chk("rm_dgnt", dmp_gnt, 1'b1);
        next_cyc();
        dmp_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rm_rvalid", dmp_rvalid, 1'b0);
        chk("rm_stall", stall_req, 1'b0);
        chk("rm_busy", busy, 1'b0);
        next_cyc();
        rst_n = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rm%0d_rvalid", k), dmp_rvalid, 1'b0);
            chk($sformatf("rm%0d_busy", k), busy, 1'b0);
            next_cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
